port_scheduler_4rad: RTL and testbench
======================================

PORT_SCHEDULER_4RAD -- requirements
Module: port_scheduler_4rad

Interface
REQ-001 SHALL have parameter PORTS, localparam 4, the radix of the switch node.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 64, the stall limit for the lock watchdog.
REQ-003 SHALL have port clk  input  1  the single clock; all state on posedge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port in_valid  input  [PORTS]  input i presents a flit.
REQ-006 SHALL have port in_type  input  [PORTS][2]  flit type (header bits 17:16): 2'b10 HEAD, 2'b00 BODY, 2'b01 TAIL, 2'b11 SINGLE.
REQ-007 SHALL have port in_route  input  [PORTS][2]  destination output (header bits 15:14); valid only on HEAD/SINGLE.
REQ-008 SHALL have port in_ready  output  [PORTS]  input i flit accepted this cycle when in_valid&in_ready.
REQ-009 SHALL have port out_ready  input  [PORTS]  downstream of output o can accept.
REQ-010 SHALL have port out_valid  output  [PORTS]  output o carries a flit.
REQ-011 SHALL have port sel  output  [PORTS][PORTS]  per output, one-hot source input; all-zero when idle (drives the node mux).
REQ-012 SHALL have port timeout_err  output  [PORTS]  one-cycle pulse when output o's lock is forcibly released.

Function
REQ-013 Each output o SHALL run an FSM with states IDLE and LOCKED, plus a 2-bit round-robin pointer ptr[o].
REQ-014 In IDLE, input i SHALL request o when in_valid[i], in_type[i] is HEAD or SINGLE, in_route[i]==o, and i owns no output.
REQ-015 Winner SHALL be the first requester searching ptr[o], ptr[o]+1, ... mod 4; ptr[o] becomes winner+1 mod 4 on grant.
REQ-016 Grant SHALL be registered: request in cycle N -> state LOCKED and sel[o] one-hot in cycle N+1.
REQ-017 Simultaneous requests from one input cannot occur (single route); two outputs granting in the same cycle SHALL be independent.
REQ-018 out_valid[o] SHALL equal LOCKED & in_valid[owner]; in_ready[i] SHALL equal out_ready[o] for the o locked to i, else 0 (combinational from registered state).
REQ-019 A BODY/TAIL flit on an input owning no output SHALL be held with in_ready=0 and never request.
REQ-020 Transfer of a TAIL or SINGLE flit in cycle N SHALL return o to IDLE with sel[o]=0 in N+1; earliest new grant visible N+2.
REQ-021 While LOCKED, sel[o] and ownership SHALL not change regardless of other requests.

Reset
REQ-022 On rst_n low: all FSMs IDLE, ptr=0, sel=0, out_valid=0, in_ready=0, timeout_err=0, stall counters 0.
REQ-023 Reset mid-packet SHALL drop all locks immediately; no flit accepted until rst_n deasserted.

Configuration
REQ-024 With SWITCH_SCHED_TIMEOUT_EN defined, a per-output counter SHALL count consecutive LOCKED cycles without transfer, cleared on any transfer; at TIMEOUT_CYCLES it SHALL force IDLE next cycle and pulse timeout_err[o] one cycle.
REQ-025 Without SWITCH_SCHED_TIMEOUT_EN, no counters SHALL exist, locks hold indefinitely, timeout_err tied 0.

Structure
REQ-026 Package switch_pkg SHALL hold PORTS, flit-type enum (HEAD/BODY/TAIL/SINGLE) and the output FSM state enum.
REQ-027 Sub-module rr_arbiter_4 (4-bit request, 2-bit pointer -> one-hot grant) SHALL be instantiated once per output.

Verification
REQ-028 Reset then in0 SINGLE route 2, out_ready=1 -> sel[2]=4'b0001 next cycle, in_ready[0]=1, IDLE one cycle later.
REQ-029 in0..in3 HEAD route 1 together, ptr=0 -> grants in order 0,1,2,3 across packets; ptr[1] ends at 0.
REQ-030 in1 HEAD,BODY,BODY,TAIL route 3 with out_ready low 2 cycles mid-packet -> sel[3] stays 4'b0010, no flit lost, in_ready[1] tracks out_ready[3].
REQ-031 in2 BODY with no lock -> in_ready[2]=0 indefinitely, sel all zero.
REQ-032 Macro on, TIMEOUT_CYCLES=8, lock then out_ready=0 for 8 cycles -> timeout_err pulse, sel zero next cycle; macro off -> lock held.
REQ-033 Assert rst_n low mid-packet -> all sel zero asynchronously, ptrs 0.

Source files
------------

// File: rtl/port_scheduler_4rad_pkg.sv
// switch_pkg: shared types and constants for the 4-radix switch-node port
// scheduler.
//   PORTS        radix of the node (inputs == outputs == 4)
//   PTR_W        width of an input/output index and of the round-robin pointer
//   flit_type_e  header bits 17:16 of a flit
//   out_state_e  per-output lock FSM state
// No ports; imported by the interface, the arbiter and the top.
package switch_pkg;

  localparam int unsigned PORTS = 4;
  localparam int unsigned PTR_W = 2;

  typedef enum logic [1:0] {
    FLIT_BODY   = 2'b00,
    FLIT_TAIL   = 2'b01,
    FLIT_HEAD   = 2'b10,
    FLIT_SINGLE = 2'b11
  } flit_type_e;

  typedef enum logic {
    OUT_IDLE   = 1'b0,
    OUT_LOCKED = 1'b1
  } out_state_e;

  // Flit opens a packet and may therefore request an output.
  function automatic logic is_head(input logic [1:0] t);
    return (t == FLIT_HEAD) || (t == FLIT_SINGLE);
  endfunction

  // Flit closes a packet; its transfer releases the output lock.
  function automatic logic is_last(input logic [1:0] t);
    return (t == FLIT_TAIL) || (t == FLIT_SINGLE);
  endfunction

  // Index of the set bit of a one-hot vector (0 when empty).
  function automatic logic [PTR_W-1:0] onehot_idx(input logic [PORTS-1:0] oh);
    logic [PTR_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < PORTS; i++) begin
      if (oh[i]) r = PTR_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/port_scheduler_4rad_if.sv
// port_scheduler_4rad_if: flit handshake and mux-select bundle of the
// scheduler.
//   in_valid/in_type/in_route  per-input flit presentation
//   in_ready                   per-input accept (valid & ready = transfer)
//   out_ready                  per-output downstream ready
//   out_valid                  per-output flit present
//   sel                        per-output one-hot source input, zero when idle
//   timeout_err                per-output forced-release pulse
// Modport master = traffic side (sources/sinks), slave = scheduler.
interface port_scheduler_4rad_if;
  import switch_pkg::*;

  logic [PORTS-1:0]            in_valid;
  logic [PORTS-1:0][1:0]       in_type;
  logic [PORTS-1:0][PTR_W-1:0] in_route;
  logic [PORTS-1:0]            in_ready;
  logic [PORTS-1:0]            out_ready;
  logic [PORTS-1:0]            out_valid;
  logic [PORTS-1:0][PORTS-1:0] sel;
  logic [PORTS-1:0]            timeout_err;

  modport master (
    output in_valid, in_type, in_route, out_ready,
    input  in_ready, out_valid, sel, timeout_err
  );

  modport slave (
    input  in_valid, in_type, in_route, out_ready,
    output in_ready, out_valid, sel, timeout_err
  );

endinterface

// File: rtl/port_scheduler_4rad_rr_arbiter.sv
// rr_arbiter_4: combinational round-robin arbiter, one per output.
//   req    4-bit request vector (bit i = input i)
//   ptr    2-bit priority pointer; search order ptr, ptr+1, ... mod 4
//   grant  one-hot winner, zero when no request
module rr_arbiter_4
  import switch_pkg::*;
(
  input  logic [PORTS-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [PORTS-1:0] grant
);

  logic             found;
  logic [PTR_W-1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < PORTS; k++) begin
      // 2-bit addition wraps naturally modulo the radix.
      idx = ptr + PTR_W'(k);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/port_scheduler_4rad.sv
// port_scheduler_4rad: wormhole output scheduler for a 4x4 switch node.
// Each output runs an IDLE/LOCKED FSM; in IDLE it arbitrates round-robin
// among inputs presenting a HEAD/SINGLE flit routed to it that own no other
// output, and the grant is registered. While LOCKED the owner's flits pass
// with in_ready = out_ready; transfer of a TAIL/SINGLE releases the lock.
//   clk, rst_n   clock, asynchronous active-low reset
//   bus          port_scheduler_4rad_if.slave (flit handshake, sel, timeout)
// Parameter TIMEOUT_CYCLES: stall limit of the lock watchdog.
// Build option SWITCH_SCHED_TIMEOUT_EN: when defined, a per-output counter
// of consecutive stalled LOCKED cycles forces release at TIMEOUT_CYCLES and
// pulses timeout_err; otherwise locks hold indefinitely and timeout_err = 0.
module port_scheduler_4rad
  import switch_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  port_scheduler_4rad_if.slave  bus
);

  out_state_e                  state_q [PORTS];
  out_state_e                  state_d [PORTS];
  logic [PORTS-1:0][PORTS-1:0] sel_q, sel_d;
  logic [PORTS-1:0][PTR_W-1:0] ptr_q, ptr_d;
  logic [PORTS-1:0]            tout_q, tout_d;

  logic [PORTS-1:0][PORTS-1:0] req, grant;
  logic [PORTS-1:0]            owned, locked, xfer, owner_last, stall_hit;
  logic [PORTS-1:0]            out_valid_c, in_ready_c;

  // An input owns an output exactly when some registered sel bit names it.
  always_comb begin
    owned = '0;
    for (int unsigned o = 0; o < PORTS; o++) begin
      for (int unsigned i = 0; i < PORTS; i++) begin
        owned[i] = owned[i] | sel_q[o][i];
      end
    end
  end

  always_comb begin
    req = '0;
    for (int unsigned o = 0; o < PORTS; o++) begin
      for (int unsigned i = 0; i < PORTS; i++) begin
        req[o][i] = bus.in_valid[i] & is_head(bus.in_type[i]) &
                    (bus.in_route[i] == PTR_W'(o)) & ~owned[i];
      end
    end
  end

  for (genvar o = 0; o < PORTS; o++) begin : g_arb
    rr_arbiter_4 u_arb (
      .req   (req[o]),
      .ptr   (ptr_q[o]),
      .grant (grant[o])
    );
  end

  always_comb begin
    locked     = '0;
    xfer       = '0;
    owner_last = '0;
    for (int unsigned o = 0; o < PORTS; o++) begin
      locked[o] = (state_q[o] == OUT_LOCKED);
      xfer[o]   = locked[o] & (|(sel_q[o] & bus.in_valid)) & bus.out_ready[o];
      for (int unsigned i = 0; i < PORTS; i++) begin
        owner_last[o] = owner_last[o] | (sel_q[o][i] & is_last(bus.in_type[i]));
      end
    end
  end

`ifdef SWITCH_SCHED_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [PORTS-1:0][CNT_W-1:0] cnt_q;

  // Counter holds the number of stalled LOCKED cycles already seen; the
  // stall that would make it TIMEOUT_CYCLES releases the lock instead.
  always_comb begin
    stall_hit = '0;
    for (int unsigned o = 0; o < PORTS; o++) begin
      stall_hit[o] = locked[o] & ~xfer[o] &
                     (cnt_q[o] == CNT_W'(TIMEOUT_CYCLES - 1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      for (int unsigned o = 0; o < PORTS; o++) begin
        if (!locked[o] || xfer[o] || stall_hit[o]) begin
          cnt_q[o] <= '0;
        end else begin
          cnt_q[o] <= cnt_q[o] + 1'b1;
        end
      end
    end
  end
`else
  logic [31:0] unused_timeout_cycles;
  assign unused_timeout_cycles = TIMEOUT_CYCLES;

  always_comb begin
    stall_hit = '0;
  end
`endif

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    tout_d  = '0;
    for (int unsigned o = 0; o < PORTS; o++) begin
      case (state_q[o])
        OUT_IDLE: begin
          if (|grant[o]) begin
            state_d[o] = OUT_LOCKED;
            sel_d[o]   = grant[o];
            ptr_d[o]   = onehot_idx(grant[o]) + 1'b1;
          end
        end
        OUT_LOCKED: begin
          if (xfer[o] && owner_last[o]) begin
            state_d[o] = OUT_IDLE;
            sel_d[o]   = '0;
          end else if (stall_hit[o]) begin
            state_d[o] = OUT_IDLE;
            sel_d[o]   = '0;
            tout_d[o]  = 1'b1;
          end
        end
        default: begin
          state_d[o] = OUT_IDLE;
          sel_d[o]   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned o = 0; o < PORTS; o++) begin
        state_q[o] <= OUT_IDLE;
      end
      sel_q  <= '0;
      ptr_q  <= '0;
      tout_q <= '0;
    end else begin
      for (int unsigned o = 0; o < PORTS; o++) begin
        state_q[o] <= state_d[o];
      end
      sel_q  <= sel_d;
      ptr_q  <= ptr_d;
      tout_q <= tout_d;
    end
  end

  always_comb begin
    out_valid_c = '0;
    in_ready_c  = '0;
    for (int unsigned o = 0; o < PORTS; o++) begin
      out_valid_c[o] = locked[o] & (|(sel_q[o] & bus.in_valid));
      for (int unsigned i = 0; i < PORTS; i++) begin
        if (sel_q[o][i]) in_ready_c[i] = bus.out_ready[o];
      end
    end
  end

  assign bus.in_ready    = in_ready_c;
  assign bus.out_valid   = out_valid_c;
  assign bus.sel         = sel_q;
  assign bus.timeout_err = tout_q;

endmodule

// File: tb/tb_port_scheduler_4rad.sv
// Testbench for port_scheduler_4rad: directed scenarios plus randomized
// traffic compared each cycle against a packet-level reference model
// (per-output owner, pointer and stall count kept as plain integers).
module tb_port_scheduler_4rad;
  import switch_pkg::*;

  localparam int unsigned TO = 8;
`ifdef SWITCH_SCHED_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif
  localparam logic [1:0] T_BODY   = 2'b00;
  localparam logic [1:0] T_TAIL   = 2'b01;
  localparam logic [1:0] T_HEAD   = 2'b10;
  localparam logic [1:0] T_SINGLE = 2'b11;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  port_scheduler_4rad_if bus ();

  port_scheduler_4rad #(.TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: owner input per output (-1 = free), pointer, stalls.
  int m_own   [4];
  int m_ptr   [4];
  int m_stall [4];
  bit m_err   [4];

  task automatic model_reset();
    for (int o = 0; o < 4; o++) begin
      m_own[o] = -1; m_ptr[o] = 0; m_stall[o] = 0; m_err[o] = 1'b0;
    end
  endtask

  task automatic model_step();
    int own_n [4];
    bit busy  [4];
    for (int i = 0; i < 4; i++) busy[i] = 1'b0;
    for (int o = 0; o < 4; o++) if (m_own[o] >= 0) busy[m_own[o]] = 1'b1;
    for (int o = 0; o < 4; o++) begin
      own_n[o] = m_own[o];
      m_err[o] = 1'b0;
      if (m_own[o] >= 0) begin
        if (bus.in_valid[m_own[o]] && bus.out_ready[o]) begin
          m_stall[o] = 0;
          if (bus.in_type[m_own[o]] == T_TAIL || bus.in_type[m_own[o]] == T_SINGLE)
            own_n[o] = -1;
        end else if (TIMEOUT_ON) begin
          m_stall[o]++;
          if (m_stall[o] == TO) begin
            own_n[o] = -1; m_err[o] = 1'b1; m_stall[o] = 0;
          end
        end
      end else begin
        for (int k = 0; k < 4; k++) begin
          int i;
          i = (m_ptr[o] + k) % 4;
          if (own_n[o] < 0 && bus.in_valid[i] && !busy[i] && bus.in_route[i] == 2'(o) &&
              (bus.in_type[i] == T_HEAD || bus.in_type[i] == T_SINGLE)) begin
            own_n[o] = i;
            m_ptr[o] = (i + 1) % 4;
          end
        end
      end
    end
    for (int o = 0; o < 4; o++) m_own[o] = own_n[o];
  endtask

  function automatic logic [15:0] exp_sel();
    logic [15:0] r;
    r = '0;
    for (int o = 0; o < 4; o++) if (m_own[o] >= 0) r[o*4 + m_own[o]] = 1'b1;
    return r;
  endfunction

  function automatic logic [3:0] exp_in_ready();
    logic [3:0] r;
    r = '0;
    for (int o = 0; o < 4; o++) if (m_own[o] >= 0 && bus.out_ready[o]) r[m_own[o]] = 1'b1;
    return r;
  endfunction

  function automatic logic [3:0] exp_out_valid();
    logic [3:0] r;
    r = '0;
    for (int o = 0; o < 4; o++) if (m_own[o] >= 0 && bus.in_valid[m_own[o]]) r[o] = 1'b1;
    return r;
  endfunction

  function automatic logic [3:0] exp_tout();
    logic [3:0] r;
    for (int o = 0; o < 4; o++) r[o] = m_err[o];
    return r;
  endfunction

  // One clock edge; the model advances on the inputs present at that edge.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset(); else model_step();
    #1;
  endtask

  task automatic clear_inputs();
    bus.in_valid = '0; bus.in_type = '0; bus.in_route = '0; bus.out_ready = 4'hF;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    clear_inputs();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.in_valid = 4'hF; bus.in_type = 8'hFF; bus.in_route = 8'h1B; bus.out_ready = 4'hF;
    #2;
    for (int c = 0; c < 3; c++) begin
      checks++; if (bus.sel !== 16'h0)
        begin errors++; $display("FAIL reset.sel c=%0d got=%h exp=0000", c, bus.sel); end
      checks++; if (bus.in_ready !== 4'h0)
        begin errors++; $display("FAIL reset.in_ready c=%0d got=%b exp=0000", c, bus.in_ready); end
      checks++; if (bus.out_valid !== 4'h0)
        begin errors++; $display("FAIL reset.out_valid c=%0d got=%b exp=0000", c, bus.out_valid); end
      checks++; if (bus.timeout_err !== 4'h0)
        begin errors++; $display("FAIL reset.timeout_err c=%0d got=%b exp=0000", c, bus.timeout_err); end
      tick(); #1;
    end
    model_reset();
    rst_n = 1'b1;
    clear_inputs();
    tick();
  endtask

  task automatic test_single();
    apply_reset();
    for (int c = 0; c < 3; c++) begin
      clear_inputs();
      if (c < 2) begin
        bus.in_valid[0] = 1'b1; bus.in_type[0] = T_SINGLE; bus.in_route[0] = 2'd2;
      end
      #2;
      checks++; if (bus.sel !== exp_sel())
        begin errors++; $display("FAIL single.sel c=%0d got=%h exp=%h", c, bus.sel, exp_sel()); end
      checks++; if (bus.in_ready !== exp_in_ready())
        begin errors++; $display("FAIL single.in_ready c=%0d got=%b exp=%b", c, bus.in_ready, exp_in_ready()); end
      checks++; if (bus.out_valid !== exp_out_valid())
        begin errors++; $display("FAIL single.out_valid c=%0d got=%b exp=%b", c, bus.out_valid, exp_out_valid()); end
      checks++; if (bus.timeout_err !== exp_tout())
        begin errors++; $display("FAIL single.timeout_err c=%0d got=%b exp=%b", c, bus.timeout_err, exp_tout()); end
      if (c == 1) begin
        checks++; if (bus.sel[2] !== 4'b0001)
          begin errors++; $display("FAIL single.sel2 got=%b exp=0001", bus.sel[2]); end
        checks++; if (bus.in_ready[0] !== 1'b1)
          begin errors++; $display("FAIL single.ready0 got=%b exp=1", bus.in_ready[0]); end
      end
      if (c == 2) begin
        checks++; if (bus.sel !== 16'h0)
          begin errors++; $display("FAIL single.release got=%h exp=0000", bus.sel); end
      end
      tick();
    end
  endtask

  task automatic test_rr_order();
    int         phase [4];
    logic [3:0] order [$];
    logic [3:0] prev, acc;
    apply_reset();
    for (int i = 0; i < 4; i++) phase[i] = 0;
    prev = '0;
    for (int c = 0; c < 30; c++) begin
      clear_inputs();
      for (int i = 0; i < 4; i++) begin
        bus.in_valid[i] = (phase[i] < 2);
        bus.in_type[i]  = (phase[i] == 0) ? T_HEAD : T_TAIL;
        bus.in_route[i] = 2'd1;
      end
      #2;
      checks++; if (bus.sel !== exp_sel())
        begin errors++; $display("FAIL rr.sel c=%0d got=%h exp=%h", c, bus.sel, exp_sel()); end
      checks++; if (bus.in_ready !== exp_in_ready())
        begin errors++; $display("FAIL rr.in_ready c=%0d got=%b exp=%b", c, bus.in_ready, exp_in_ready()); end
      checks++; if (bus.out_valid !== exp_out_valid())
        begin errors++; $display("FAIL rr.out_valid c=%0d got=%b exp=%b", c, bus.out_valid, exp_out_valid()); end
      checks++; if (bus.timeout_err !== exp_tout())
        begin errors++; $display("FAIL rr.timeout_err c=%0d got=%b exp=%b", c, bus.timeout_err, exp_tout()); end
      if (bus.sel[1] !== 4'b0000 && prev === 4'b0000) order.push_back(bus.sel[1]);
      prev = bus.sel[1];
      acc = bus.in_valid & exp_in_ready();
      for (int i = 0; i < 4; i++) if (acc[i]) phase[i]++;
      tick();
    end
    checks++; if (order.size() != 4)
      begin errors++; $display("FAIL rr.grant_count got=%0d exp=4", order.size()); end
    for (int k = 0; k < 4 && k < order.size(); k++) begin
      checks++; if (order[k] !== 4'(1 << k))
        begin errors++; $display("FAIL rr.order k=%0d got=%b exp=%b", k, order[k], 4'(1 << k)); end
    end
    // Pointer must have wrapped back to input 0.
    bus.in_valid = 4'hF; bus.in_type = 8'hFF; bus.in_route = 8'h55;
    tick();
    #1;
    checks++; if (bus.sel[1] !== 4'b0001)
      begin errors++; $display("FAIL rr.wrap got=%b exp=0001", bus.sel[1]); end
    checks++; if (bus.sel !== exp_sel())
      begin errors++; $display("FAIL rr.wrap_sel got=%h exp=%h", bus.sel, exp_sel()); end
    clear_inputs();
    tick();
  endtask

  task automatic test_backpressure();
    logic [1:0] pkt [4];
    int idx, in_acc, out_acc;
    pkt = '{T_HEAD, T_BODY, T_BODY, T_TAIL};
    idx = 0; in_acc = 0; out_acc = 0;
    apply_reset();
    for (int c = 0; c < 12; c++) begin
      clear_inputs();
      bus.out_ready = (c == 3 || c == 4) ? 4'b0111 : 4'b1111;
      if (idx < 4) begin
        bus.in_valid[1] = 1'b1; bus.in_type[1] = pkt[idx]; bus.in_route[1] = 2'd3;
      end
      #2;
      checks++; if (bus.sel !== exp_sel())
        begin errors++; $display("FAIL bp.sel c=%0d got=%h exp=%h", c, bus.sel, exp_sel()); end
      checks++; if (bus.in_ready !== exp_in_ready())
        begin errors++; $display("FAIL bp.in_ready c=%0d got=%b exp=%b", c, bus.in_ready, exp_in_ready()); end
      checks++; if (bus.out_valid !== exp_out_valid())
        begin errors++; $display("FAIL bp.out_valid c=%0d got=%b exp=%b", c, bus.out_valid, exp_out_valid()); end
      checks++; if (bus.timeout_err !== exp_tout())
        begin errors++; $display("FAIL bp.timeout_err c=%0d got=%b exp=%b", c, bus.timeout_err, exp_tout()); end
      if (c >= 1 && idx < 4) begin
        checks++; if (bus.sel[3] !== 4'b0010)
          begin errors++; $display("FAIL bp.sel3 c=%0d got=%b exp=0010", c, bus.sel[3]); end
        checks++; if (bus.in_ready[1] !== bus.out_ready[3])
          begin errors++; $display("FAIL bp.track c=%0d got=%b exp=%b", c, bus.in_ready[1], bus.out_ready[3]); end
      end
      if (bus.out_valid[3] === 1'b1 && bus.out_ready[3]) out_acc++;
      if (bus.in_valid[1] && bus.in_ready[1] === 1'b1) begin in_acc++; idx++; end
      tick();
    end
    checks++; if (in_acc != 4)
      begin errors++; $display("FAIL bp.in_flits got=%0d exp=4", in_acc); end
    checks++; if (out_acc != 4)
      begin errors++; $display("FAIL bp.out_flits got=%0d exp=4", out_acc); end
  endtask

  task automatic test_body_no_lock();
    apply_reset();
    for (int c = 0; c < 12; c++) begin
      clear_inputs();
      bus.in_valid[2] = 1'b1;
      bus.in_type[2]  = (c < 8) ? T_BODY : T_TAIL;
      bus.in_route[2] = 2'(c % 4);
      #2;
      checks++; if (bus.in_ready[2] !== 1'b0)
        begin errors++; $display("FAIL body.ready2 c=%0d got=%b exp=0", c, bus.in_ready[2]); end
      checks++; if (bus.sel !== 16'h0)
        begin errors++; $display("FAIL body.sel c=%0d got=%h exp=0000", c, bus.sel); end
      checks++; if (bus.out_valid !== 4'h0)
        begin errors++; $display("FAIL body.out_valid c=%0d got=%b exp=0000", c, bus.out_valid); end
      tick();
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < 4; i++) begin
        bus.in_valid[i]  = ($urandom_range(0, 3) != 0);
        bus.in_type[i]   = 2'($urandom_range(0, 3));
        bus.in_route[i]  = 2'($urandom_range(0, 3));
        bus.out_ready[i] = ($urandom_range(0, 3) != 0);
      end
      #2;
      checks++; if (bus.sel !== exp_sel())
        begin errors++; $display("FAIL rand.sel c=%0d got=%h exp=%h", c, bus.sel, exp_sel()); end
      checks++; if (bus.in_ready !== exp_in_ready())
        begin errors++; $display("FAIL rand.in_ready c=%0d got=%b exp=%b", c, bus.in_ready, exp_in_ready()); end
      checks++; if (bus.out_valid !== exp_out_valid())
        begin errors++; $display("FAIL rand.out_valid c=%0d got=%b exp=%b", c, bus.out_valid, exp_out_valid()); end
      checks++; if (bus.timeout_err !== exp_tout())
        begin errors++; $display("FAIL rand.timeout_err c=%0d got=%b exp=%b", c, bus.timeout_err, exp_tout()); end
      tick();
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    for (int c = 0; c < 14; c++) begin
      clear_inputs();
      bus.out_ready = 4'h0;
      bus.in_valid[0] = 1'b1; bus.in_type[0] = T_HEAD; bus.in_route[0] = 2'd0;
      #2;
      checks++; if (bus.sel !== exp_sel())
        begin errors++; $display("FAIL tmo.sel c=%0d got=%h exp=%h", c, bus.sel, exp_sel()); end
      checks++; if (bus.in_ready !== exp_in_ready())
        begin errors++; $display("FAIL tmo.in_ready c=%0d got=%b exp=%b", c, bus.in_ready, exp_in_ready()); end
      checks++; if (bus.out_valid !== exp_out_valid())
        begin errors++; $display("FAIL tmo.out_valid c=%0d got=%b exp=%b", c, bus.out_valid, exp_out_valid()); end
      checks++; if (bus.timeout_err !== exp_tout())
        begin errors++; $display("FAIL tmo.timeout_err c=%0d got=%b exp=%b", c, bus.timeout_err, exp_tout()); end
      if (c == 5) begin
        checks++; if (bus.sel[0] !== 4'b0001)
          begin errors++; $display("FAIL tmo.held got=%b exp=0001", bus.sel[0]); end
      end
      if (c == 9) begin
        checks++; if (bus.sel[0] !== (TIMEOUT_ON ? 4'b0000 : 4'b0001))
          begin errors++; $display("FAIL tmo.release got=%b exp=%b", bus.sel[0], TIMEOUT_ON ? 4'b0000 : 4'b0001); end
        checks++; if (bus.timeout_err[0] !== TIMEOUT_ON)
          begin errors++; $display("FAIL tmo.pulse got=%b exp=%b", bus.timeout_err[0], TIMEOUT_ON); end
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int c = 0; c < 3; c++) begin
      clear_inputs();
      bus.in_valid[1] = 1'b1; bus.in_type[1] = (c < 2) ? T_HEAD : T_BODY; bus.in_route[1] = 2'd3;
      #2;
      checks++; if (bus.sel !== exp_sel())
        begin errors++; $display("FAIL arst.sel c=%0d got=%h exp=%h", c, bus.sel, exp_sel()); end
      checks++; if (bus.in_ready !== exp_in_ready())
        begin errors++; $display("FAIL arst.in_ready c=%0d got=%b exp=%b", c, bus.in_ready, exp_in_ready()); end
      checks++; if (bus.out_valid !== exp_out_valid())
        begin errors++; $display("FAIL arst.out_valid c=%0d got=%b exp=%b", c, bus.out_valid, exp_out_valid()); end
      if (c < 2) tick();
    end
    // Mid-cycle reset while in1 still holds output 3.
    rst_n = 1'b0;
    #1;
    checks++; if (bus.sel !== 16'h0)
      begin errors++; $display("FAIL arst.sel_async got=%h exp=0000", bus.sel); end
    checks++; if (bus.in_ready !== 4'h0)
      begin errors++; $display("FAIL arst.ready_async got=%b exp=0000", bus.in_ready); end
    checks++; if (bus.out_valid !== 4'h0)
      begin errors++; $display("FAIL arst.valid_async got=%b exp=0000", bus.out_valid); end
    tick();
    checks++; if (bus.in_ready !== 4'h0)
      begin errors++; $display("FAIL arst.ready_held got=%b exp=0000", bus.in_ready); end
    rst_n = 1'b1;
    bus.in_valid = 4'hF; bus.in_type = 8'hFF; bus.in_route = 8'hFF;
    #2;
    checks++; if (bus.sel !== 16'h0)
      begin errors++; $display("FAIL arst.idle got=%h exp=0000", bus.sel); end
    tick();
    #1;
    checks++; if (bus.sel[3] !== 4'b0001)
      begin errors++; $display("FAIL arst.ptr0 got=%b exp=0001", bus.sel[3]); end
    checks++; if (bus.sel !== exp_sel())
      begin errors++; $display("FAIL arst.sel_after got=%h exp=%h", bus.sel, exp_sel()); end
    clear_inputs();
    tick();
  endtask

  initial begin
    model_reset();
    clear_inputs();
    test_reset();
    test_single();
    test_rr_order();
    test_backpressure();
    test_body_no_lock();
    test_random();
    test_timeout();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
